tick_watch: RTL

TICK_WATCH -- requirements
Module: tick_watch

---
 rtl/tick_watch.sv | 99 +++++++++
 1 files changed

// File: rtl/tick_watch.sv
// tick_watch: monitors a periodic tick, measures its period and reports lock, timeout
// and short-period errors.
module tick_watch #(
    parameter logic [31:0] TIMEOUT    = 32'd100000000,
    parameter logic [31:0] MIN_PERIOD = 32'd1000,
    parameter logic [7:0]  LOCK_COUNT = 8'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_in,
    input  logic        clr,
    output logic        alive,
    output logic        lost,
    output logic        too_fast,
    output logic [31:0] period,
    output logic        period_valid,
    output logic [7:0]  err_cnt
);
    typedef enum logic [1:0] {IDLE, ACQ, LOCK, LOST} state_t;
    state_t state, state_nxt;
    logic sync1, sync2, hist, ready, armed, tick_edge;
    logic short_err, timeout, pv_nxt;
    logic [31:0] cnt, meas;
    logic [7:0] good, good_nxt;
    // armed needs a real low sample after reset, so a level already high at release is no edge
    assign tick_edge = sync2 & ~hist & armed;
    assign meas = cnt + 32'd1;
    assign timeout = (cnt == TIMEOUT) & ~tick_edge & (state == ACQ || state == LOCK);
    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        pv_nxt    = 1'b0;
        short_err = 1'b0;
        if (tick_edge) begin
            case (state)
                IDLE, LOST: begin
                    state_nxt = ACQ;
                    good_nxt  = '0;
                end
                default: begin
                    if (meas >= MIN_PERIOD) begin
                        pv_nxt = 1'b1;
                        if (state == ACQ) begin
                            good_nxt  = good + 8'd1;
                            state_nxt = (good_nxt >= LOCK_COUNT) ? LOCK : ACQ;
                        end
                    end else begin
                        short_err = 1'b1;
                        good_nxt  = '0;
                        state_nxt = ACQ;
                    end
                end
            endcase
        end else if (timeout) begin
            state_nxt = LOST;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sync1, sync2, hist, ready, armed} <= '0;
            state        <= IDLE;
            cnt          <= '0;
            good         <= '0;
            period       <= '0;
            err_cnt      <= '0;
            alive        <= 1'b0;
            lost         <= 1'b0;
            too_fast     <= 1'b0;
            period_valid <= 1'b0;
        end else begin
            sync1 <= tick_in;
            sync2 <= sync1;
            hist  <= sync2;
            ready <= 1'b1;
            armed <= armed | (ready & ~sync1);
            if (clr) begin
                state        <= IDLE;
                cnt          <= '0;
                good         <= '0;
                period       <= '0;
                err_cnt      <= '0;
                alive        <= 1'b0;
                lost         <= 1'b0;
                too_fast     <= 1'b0;
                period_valid <= 1'b0;
            end else begin
                state        <= state_nxt;
                cnt          <= tick_edge ? '0 : (cnt == TIMEOUT ? cnt : cnt + 32'd1);
                good         <= good_nxt;
                period       <= pv_nxt ? meas : period;
                err_cnt      <= ((short_err | timeout) && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
                alive        <= state_nxt == LOCK;
                lost         <= state_nxt == LOST;
                too_fast     <= short_err;
                period_valid <= pv_nxt;
            end
        end
    end
endmodule
